// File: rtl/clk_reset_seq_pkg.sv
// ---------------------------------------------------------------------------
// clk_reset_seq_pkg
//
// Shared definitions for the post-PLL reset sequencer:
//   - seq_state_e  : sequencer state encoding (HOLD, FILTER, RELEASE, RUN)
//   - DEF_*        : default values for the sequencer parameters
//   - LOSS_CNT_W   : width of the saturating lock-loss debug counter
//   - cntWidth()   : width needed to hold the values 0..maxVal
//   - satInc()     : saturating increment for the lock-loss counter
// ---------------------------------------------------------------------------
package clk_reset_seq_pkg;

  // The sequencer walks HOLD -> FILTER -> RELEASE -> RUN.
  // Any fault sends it straight back to HOLD.
  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    FILTER  = 2'd1,
    RELEASE = 2'd2,
    RUN     = 2'd3
  } seq_state_e;

  // Default parameter values, sized for real board timing.
  localparam int unsigned DEF_STAGES      = 3;
  localparam int unsigned DEF_LOCK_FILTER = 1024;
  localparam int unsigned DEF_STAGE_DELAY = 4096;
  localparam int unsigned DEF_DEBOUNCE    = 65536;

  // The lock-loss counter is a fixed 8-bit debug register.
  localparam int unsigned LOSS_CNT_W = 8;
  typedef logic [LOSS_CNT_W-1:0] loss_cnt_t;

  // Counter widths are $clog2(max+1), with a floor of one bit so that
  // degenerate parameter values never produce a zero-width vector.
  function automatic int unsigned cntWidth(input int unsigned maxVal);
    return (maxVal < 1) ? 1 : $clog2(maxVal + 1);
  endfunction

  // Increment that sticks at all-ones instead of wrapping.
  function automatic loss_cnt_t satInc(input loss_cnt_t value);
    return (value == '1) ? value : value + 1'b1;
  endfunction

endpackage : clk_reset_seq_pkg

// File: rtl/clk_reset_seq_sync_debounce.sv
// ---------------------------------------------------------------------------
// clk_reset_seq_sync_debounce
//
// Two-flop synchroniser for an asynchronous level, optionally followed by a
// symmetric debounce filter.
//
// With DEBOUNCE = 0 the filter is bypassed and level_o is the synchroniser
// output (two edges of latency).
// With DEBOUNCE > 0 level_o only changes after the synchronised input has
// disagreed with it for DEBOUNCE consecutive cycles; any agreeing sample
// restarts the count. Both directions use the same count.
//
// Parameters:
//   DEBOUNCE   : consecutive disagreeing samples needed to flip level_o
//                (0 = no filtering)
//
// Ports:
//   clock_i    in  1  sampling clock
//   reset_n_i  in  1  asynchronous active-low reset
//   async_i    in  1  asynchronous input level
//   level_o    out 1  synchronised (and optionally debounced) level
//
// Reset state: synchroniser flops 0; the debounced level resets to 1, which
// is the idle level of the active-low inputs this block serves.
// ---------------------------------------------------------------------------
module clk_reset_seq_sync_debounce
  import clk_reset_seq_pkg::*;
#(
  parameter int unsigned DEBOUNCE = DEF_DEBOUNCE
) (
  input  logic clock_i,
  input  logic reset_n_i,
  input  logic async_i,
  output logic level_o
);

  // Bit 0 is the metastability-catching flop, bit 1 the usable sample.
  logic [1:0] syncChain_q;

  // Plain two-flop synchroniser; shifting the raw input in each cycle.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      syncChain_q <= '0;
    end else begin
      syncChain_q <= {syncChain_q[0], async_i};
    end
  end

  generate
    if (DEBOUNCE == 0) begin : gBypass

      assign level_o = syncChain_q[1];

    end else begin : gDebounce

      localparam int unsigned CNT_W = cntWidth(DEBOUNCE);
      localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE - 1);

      logic [CNT_W-1:0] stableCnt_q;
      logic [CNT_W-1:0] stableCnt_d;
      logic             level_q;
      logic             level_d;

      // Count samples that disagree with the current level. The count is
      // cleared by any agreeing sample and also when the level flips, so
      // the DEBOUNCE-th consecutive disagreeing sample is the one that
      // changes the output.
      always_comb begin
        level_d     = level_q;
        stableCnt_d = '0;
        if (syncChain_q[1] != level_q) begin
          if (stableCnt_q == CNT_MAX) begin
            level_d = ~level_q;
          end else begin
            stableCnt_d = stableCnt_q + 1'b1;
          end
        end
      end

      // Debounce state registers; the level starts at the idle (released)
      // value so a freshly reset button does not read as pressed.
      always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
          stableCnt_q <= '0;
          level_q     <= 1'b1;
        end else begin
          stableCnt_q <= stableCnt_d;
          level_q     <= level_d;
        end
      end

      assign level_o = level_q;

    end
  endgenerate

endmodule : clk_reset_seq_sync_debounce

// File: rtl/clk_reset_seq.sv
// ---------------------------------------------------------------------------
// clk_reset_seq
//
// Reset sequencer placed directly after the board PLL. It waits for a
// filtered PLL lock with the user button released, then de-asserts the
// per-domain active-low resets one at a time (memory controller, video,
// CPU core). Any lock loss or debounced button press pulls every domain
// back into reset on the same edge and restarts the whole sequence.
//
// Parameters:
//   STAGES       : number of sequenced reset outputs (>= 1)
//   LOCK_FILTER  : consecutive clean cycles before sequencing starts
//   STAGE_DELAY  : cycles before stage 0 and between later stages
//   DEBOUNCE     : stable cycles for the button to change state
//
// Ports:
//   clock          in  1        PLL output clock
//   reset_n        in  1        asynchronous active-low reset
//   pll_locked     in  1        PLL lock, asynchronous
//   btn_n          in  1        user reset button, active-low, asynchronous
//   rst_n_out      out STAGES   per-stage active-low resets, bit 0 first
//   ready          out 1        all stages released
//   lock_loss_cnt  out 8        saturating count of lock-loss events
//
// Timing: with T0 the first edge at which HOLD sees no fault, stage k is
// released at T0 + LOCK_FILTER + (k+1)*STAGE_DELAY and ready rises with the
// last stage. All outputs come straight from flops.
// ---------------------------------------------------------------------------
module clk_reset_seq
  import clk_reset_seq_pkg::*;
#(
  parameter int unsigned STAGES      = DEF_STAGES,
  parameter int unsigned LOCK_FILTER = DEF_LOCK_FILTER,
  parameter int unsigned STAGE_DELAY = DEF_STAGE_DELAY,
  parameter int unsigned DEBOUNCE    = DEF_DEBOUNCE
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  pll_locked,
  input  logic                  btn_n,
  output logic [STAGES-1:0]     rst_n_out,
  output logic                  ready,
  output logic [LOSS_CNT_W-1:0] lock_loss_cnt
);

  localparam int unsigned FILT_W  = cntWidth(LOCK_FILTER);
  localparam int unsigned DELAY_W = cntWidth(STAGE_DELAY);
  localparam int unsigned IDX_W   = cntWidth(STAGES);

  localparam logic [FILT_W-1:0]  FILT_MAX  = FILT_W'(LOCK_FILTER - 1);
  localparam logic [DELAY_W-1:0] DELAY_MAX = DELAY_W'(STAGE_DELAY - 1);
  localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(STAGES - 1);

  logic lockedS;
  logic btnLevel;
  logic pressed;
  logic fault;

  seq_state_e         state_q;
  logic [FILT_W-1:0]  filtCnt_q;
  logic [DELAY_W-1:0] delayCnt_q;
  logic [IDX_W-1:0]   stageIdx_q;
  logic [STAGES-1:0]  rstN_q;
  logic               ready_q;
  logic [STAGES-1:0]  releaseMask;

  logic               lockedPrev_q;
  loss_cnt_t          lossCnt_q;
  loss_cnt_t          lossCnt_d;

  // The PLL lock only needs synchronising: the lock filter further down
  // already demands a long run of clean cycles.
  clk_reset_seq_sync_debounce #(
    .DEBOUNCE (0)
  ) uLockSync (
    .clock_i   (clock),
    .reset_n_i (reset_n),
    .async_i   (pll_locked),
    .level_o   (lockedS)
  );

  // The button is synchronised and debounced; its level resets to
  // "released" so pressed starts at 0.
  clk_reset_seq_sync_debounce #(
    .DEBOUNCE (DEBOUNCE)
  ) uBtnDebounce (
    .clock_i   (clock),
    .reset_n_i (reset_n),
    .async_i   (btn_n),
    .level_o   (btnLevel)
  );

  assign pressed = ~btnLevel;
  assign fault   = ~lockedS | pressed;

  // One-hot mask selecting the stage that the current RELEASE step frees.
  always_comb begin
    releaseMask = '0;
    for (int i = 0; i < STAGES; i++) begin
      if (stageIdx_q == IDX_W'(i)) begin
        releaseMask[i] = 1'b1;
      end
    end
  end

  // Sequencer FSM. A fault in any state drops every reset output and ready
  // on the same edge; release order is deliberately not mirrored on
  // assertion. In HOLD the outputs are already low, so the common fault
  // branch covers HOLD as well. No progress is kept across a fault.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= HOLD;
      filtCnt_q  <= '0;
      delayCnt_q <= '0;
      stageIdx_q <= '0;
      rstN_q     <= '0;
      ready_q    <= 1'b0;
    end else if (fault) begin
      state_q    <= HOLD;
      filtCnt_q  <= '0;
      delayCnt_q <= '0;
      stageIdx_q <= '0;
      rstN_q     <= '0;
      ready_q    <= 1'b0;
    end else begin
      case (state_q)
        HOLD: begin
          state_q   <= FILTER;
          filtCnt_q <= '0;
        end

        FILTER: begin
          if (filtCnt_q == FILT_MAX) begin
            state_q    <= RELEASE;
            delayCnt_q <= '0;
            stageIdx_q <= '0;
          end else begin
            filtCnt_q <= filtCnt_q + 1'b1;
          end
        end

        RELEASE: begin
          if (delayCnt_q == DELAY_MAX) begin
            rstN_q     <= rstN_q | releaseMask;
            delayCnt_q <= '0;
            stageIdx_q <= stageIdx_q + 1'b1;
            if (stageIdx_q == LAST_IDX) begin
              state_q <= RUN;
              ready_q <= 1'b1;
            end
          end else begin
            delayCnt_q <= delayCnt_q + 1'b1;
          end
        end

        RUN: begin
          state_q <= RUN;
        end

        default: begin
          state_q <= HOLD;
          rstN_q  <= '0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  // A lock-loss event is a falling edge of the synchronised lock, counted
  // in every state, including one that coincides with a button press.
  always_comb begin
    lossCnt_d = lossCnt_q;
    if (lockedPrev_q && !lockedS) begin
      lossCnt_d = satInc(lossCnt_q);
    end
  end

  // Lock-loss history; only reset_n clears the counter.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lockedPrev_q <= 1'b0;
      lossCnt_q    <= '0;
    end else begin
      lockedPrev_q <= lockedS;
      lossCnt_q    <= lossCnt_d;
    end
  end

  assign rst_n_out     = rstN_q;
  assign ready         = ready_q;
  assign lock_loss_cnt = lossCnt_q;

endmodule : clk_reset_seq

// File: tb/tb_clk_reset_seq.sv
// ---------------------------------------------------------------------------
// tb_clk_reset_seq
//
// Directed bench for clk_reset_seq with STAGES=3, LOCK_FILTER=4,
// STAGE_DELAY=8, DEBOUNCE=4. Expected values are hand-derived edge counts.
// Inputs are driven and outputs sampled 1 time unit after a rising edge.
// ---------------------------------------------------------------------------
module tb_clk_reset_seq;

  localparam int STAGES      = 3;
  localparam int LOCK_FILTER = 4;
  localparam int STAGE_DELAY = 8;
  localparam int DEBOUNCE    = 4;

  logic              clock = 1'b0;
  logic              reset_n;
  logic              pll_locked;
  logic              btn_n;
  logic [STAGES-1:0] rst_n_out;
  logic              ready;
  logic [7:0]        lock_loss_cnt;

  int checkCount = 0;
  int errorCount = 0;

  always #5 clock = ~clock;

  clk_reset_seq #(
    .STAGES      (STAGES),
    .LOCK_FILTER (LOCK_FILTER),
    .STAGE_DELAY (STAGE_DELAY),
    .DEBOUNCE    (DEBOUNCE)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .pll_locked    (pll_locked),
    .btn_n         (btn_n),
    .rst_n_out     (rst_n_out),
    .ready         (ready),
    .lock_loss_cnt (lock_loss_cnt)
  );

  // Advance n rising edges and settle just after the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Drive the two asynchronous inputs, then run for a number of edges.
  task automatic applyStimulus(input logic lock, input logic btn, input int cycles);
    pll_locked = lock;
    btn_n      = btn;
    tick(cycles);
  endtask

  // Single comparison point: counts every check, reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic checkSeq(input string tag, input logic [2:0] expRst, input logic expReady);
    checkOutput({tag, "_rst"}, 32'(rst_n_out), 32'(expRst));
    checkOutput({tag, "_rdy"}, 32'(ready), 32'(expReady));
  endtask

  // Called right after the stimulus that makes the next edge E; checks
  // stage 0 rises exactly at E+k and the later stages follow every 8 edges.
  task automatic checkRelease(input string tag, input int k);
    tick(k);
    checkSeq({tag, "_pre0"}, 3'b000, 1'b0);
    tick(1);
    checkSeq({tag, "_st0"}, 3'b001, 1'b0);
    tick(STAGE_DELAY - 1);
    checkSeq({tag, "_pre1"}, 3'b001, 1'b0);
    tick(1);
    checkSeq({tag, "_st1"}, 3'b011, 1'b0);
    tick(STAGE_DELAY - 1);
    checkSeq({tag, "_pre2"}, 3'b011, 1'b0);
    tick(1);
    checkSeq({tag, "_st2"}, 3'b111, 1'b1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    // Reset state, checked asynchronously before any clock edge.
    reset_n    = 1'b0;
    pll_locked = 1'b0;
    btn_n      = 1'b1;
    #3;
    checkSeq("reset", 3'b000, 1'b0);
    checkOutput("reset_loss", 32'(lock_loss_cnt), 32'd0);
    #14;
    reset_n = 1'b1;
    tick(5);
    checkSeq("hold_nolock", 3'b000, 1'b0);

    // Clean start: lock raised before edge E, stage 0 at E+14.
    pll_locked = 1'b1;
    checkRelease("clean", 14);
    checkOutput("clean_loss", 32'(lock_loss_cnt), 32'd0);

    // Lock loss in RUN: outputs drop exactly two edges after the drop.
    applyStimulus(1'b0, 1'b1, 1);
    checkSeq("loss_e0", 3'b111, 1'b1);
    tick(1);
    checkSeq("loss_e1", 3'b111, 1'b1);
    tick(1);
    checkSeq("loss_e2", 3'b000, 1'b0);
    checkOutput("loss_cnt1", 32'(lock_loss_cnt), 32'd1);
    tick(3);
    pll_locked = 1'b1;
    checkRelease("relock", 14);

    // Async reset mid-RELEASE with one stage already released.
    applyStimulus(1'b0, 1'b1, 4);
    checkOutput("loss_cnt2", 32'(lock_loss_cnt), 32'd2);
    pll_locked = 1'b1;
    tick(15);
    checkSeq("midrel", 3'b001, 1'b0);
    tick(2);
    reset_n = 1'b0;
    #2;
    checkSeq("async_rst", 3'b000, 1'b0);
    checkOutput("async_rst_loss", 32'(lock_loss_cnt), 32'd0);
    #2;
    reset_n = 1'b1;

    // Lock glitch in FILTER: T0 moves from E+2 to E+7.
    tick(4);
    pll_locked = 1'b0;
    tick(1);
    pll_locked = 1'b1;
    checkRelease("glitch", 14);
    checkOutput("glitch_loss", 32'(lock_loss_cnt), 32'd1);

    // Button bounce shorter than DEBOUNCE has no effect.
    applyStimulus(1'b1, 1'b0, 3);
    applyStimulus(1'b1, 1'b1, 10);
    checkSeq("bounce3", 3'b111, 1'b1);

    // Six-cycle press: outputs drop on edge P+6, release restarts after
    // the button has been stably high again; stage 0 at P+24.
    applyStimulus(1'b1, 1'b0, 6);
    checkSeq("press_p5", 3'b111, 1'b1);
    applyStimulus(1'b1, 1'b1, 1);
    checkSeq("press_p6", 3'b000, 1'b0);
    checkRelease("btnrel", 17);
    checkOutput("btn_loss", 32'(lock_loss_cnt), 32'd1);

    // Saturation: 1 + 253 events = 254, then 47 more sticks at 255.
    for (int i = 0; i < 253; i++) begin
      applyStimulus(1'b0, 1'b1, 1);
      applyStimulus(1'b1, 1'b1, 1);
    end
    tick(3);
    checkOutput("loss_254", 32'(lock_loss_cnt), 32'd254);
    for (int i = 0; i < 47; i++) begin
      applyStimulus(1'b0, 1'b1, 1);
      applyStimulus(1'b1, 1'b1, 1);
    end
    tick(3);
    checkOutput("loss_sat", 32'(lock_loss_cnt), 32'd255);
    reset_n = 1'b0;
    #2;
    checkOutput("loss_clear", 32'(lock_loss_cnt), 32'd0);
    reset_n = 1'b1;
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule : tb_clk_reset_seq
